// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline boundary: registers the execute result and control into MEM and resolves
// the control-flow redirect. Optional statistics counters are enabled by BRANCH_STAT_EN.
module ex_mem_stage #(
  parameter logic [31:0] RESET_PC_MASK = 32'hFFFF_FFFE
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_stall,
  input  logic        ex_valid,
  input  logic [31:0] ex_pc,
  input  logic [31:0] ex_imm,
  input  logic [31:0] ex_alu_c,
  input  logic        ex_flush,
  input  logic        ex_jalr,
  input  logic        ex_link,
  input  logic [31:0] ex_rs2_data,
  input  logic [4:0]  ex_rd,
  input  logic        ex_regwrite,
  input  logic        ex_memread,
  input  logic        ex_memwrite,
  input  logic [2:0]  ex_dmtype,
  input  logic [1:0]  ex_wdsel,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic        kill_ifid,
  output logic        kill_idex,
  output logic        mem_valid,
  output logic        mem_regwrite,
  output logic        mem_memread,
  output logic        mem_memwrite,
  output logic [31:0] mem_alu_out,
  output logic [31:0] mem_store_data,
  output logic [31:0] mem_pc,
  output logic [4:0]  mem_rd,
  output logic [2:0]  mem_dmtype,
  output logic [1:0]  mem_wdsel,
  output logic [31:0] stat_redirects,
  output logic [31:0] stat_retired
);

  logic        valid_q, regwrite_q, memread_q, memwrite_q;
  logic [31:0] alu_out_q, store_data_q, pc_q;
  logic [4:0]  rd_q;
  logic [2:0]  dmtype_q;
  logic [1:0]  wdsel_q;
  logic [31:0] alu_out_d;

  always_comb begin
    redirect_pc    = ex_jalr ? (ex_alu_c & RESET_PC_MASK) : (ex_pc + ex_imm);
    redirect_valid = ex_valid & ex_flush & ~mem_stall & ~rst;
    kill_ifid      = redirect_valid;
    kill_idex      = redirect_valid;
    alu_out_d      = ex_link ? (ex_pc + 32'd4) : ex_alu_c;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q      <= 1'b0;
      regwrite_q   <= 1'b0;
      memread_q    <= 1'b0;
      memwrite_q   <= 1'b0;
      alu_out_q    <= '0;
      store_data_q <= '0;
      pc_q         <= '0;
      rd_q         <= '0;
      dmtype_q     <= '0;
      wdsel_q      <= '0;
    end else if (!mem_stall) begin
      // A bubble clears the control bits; data fields are don't-care and load anyway.
      valid_q      <= ex_valid;
      regwrite_q   <= ex_valid & ex_regwrite;
      memread_q    <= ex_valid & ex_memread;
      memwrite_q   <= ex_valid & ex_memwrite;
      alu_out_q    <= alu_out_d;
      store_data_q <= ex_rs2_data;
      pc_q         <= ex_pc;
      rd_q         <= ex_rd;
      dmtype_q     <= ex_dmtype;
      wdsel_q      <= ex_wdsel;
    end
  end

  assign mem_valid      = valid_q;
  assign mem_regwrite   = regwrite_q;
  assign mem_memread    = memread_q;
  assign mem_memwrite   = memwrite_q;
  assign mem_alu_out    = alu_out_q;
  assign mem_store_data = store_data_q;
  assign mem_pc         = pc_q;
  assign mem_rd         = rd_q;
  assign mem_dmtype     = dmtype_q;
  assign mem_wdsel      = wdsel_q;

`ifdef BRANCH_STAT_EN
  logic [31:0] stat_red_q, stat_ret_q;

  // Saturating counters; they only move on advancing cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_red_q <= '0;
      stat_ret_q <= '0;
    end else if (!mem_stall) begin
      if (redirect_valid && (stat_red_q != 32'hFFFF_FFFF)) stat_red_q <= stat_red_q + 32'd1;
      if (ex_valid && (stat_ret_q != 32'hFFFF_FFFF)) stat_ret_q <= stat_ret_q + 32'd1;
    end
  end

  assign stat_redirects = stat_red_q;
  assign stat_retired   = stat_ret_q;
`else
  assign stat_redirects = '0;
  assign stat_retired   = '0;
`endif

endmodule

// File: tb/tb_ex_mem_stage.sv
// Randomized self-checking bench for ex_mem_stage against a cycle-level behavioural model.
module tb_ex_mem_stage;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, mem_stall, ex_valid, ex_flush, ex_jalr, ex_link;
  logic [31:0] ex_pc, ex_imm, ex_alu_c, ex_rs2_data;
  logic [4:0]  ex_rd;
  logic        ex_regwrite, ex_memread, ex_memwrite;
  logic [2:0]  ex_dmtype;
  logic [1:0]  ex_wdsel;
  logic        redirect_valid, kill_ifid, kill_idex;
  logic [31:0] redirect_pc;
  logic        mem_valid, mem_regwrite, mem_memread, mem_memwrite;
  logic [31:0] mem_alu_out, mem_store_data, mem_pc;
  logic [4:0]  mem_rd;
  logic [2:0]  mem_dmtype;
  logic [1:0]  mem_wdsel;
  logic [31:0] stat_redirects, stat_retired;

  ex_mem_stage dut (
    .clk(clk), .rst(rst), .mem_stall(mem_stall), .ex_valid(ex_valid), .ex_pc(ex_pc),
    .ex_imm(ex_imm), .ex_alu_c(ex_alu_c), .ex_flush(ex_flush), .ex_jalr(ex_jalr),
    .ex_link(ex_link), .ex_rs2_data(ex_rs2_data), .ex_rd(ex_rd), .ex_regwrite(ex_regwrite),
    .ex_memread(ex_memread), .ex_memwrite(ex_memwrite), .ex_dmtype(ex_dmtype),
    .ex_wdsel(ex_wdsel), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .kill_ifid(kill_ifid), .kill_idex(kill_idex), .mem_valid(mem_valid),
    .mem_regwrite(mem_regwrite), .mem_memread(mem_memread), .mem_memwrite(mem_memwrite),
    .mem_alu_out(mem_alu_out), .mem_store_data(mem_store_data), .mem_pc(mem_pc),
    .mem_rd(mem_rd), .mem_dmtype(mem_dmtype), .mem_wdsel(mem_wdsel),
    .stat_redirects(stat_redirects), .stat_retired(stat_retired)
  );

`ifdef BRANCH_STAT_EN
  localparam bit StatEn = 1'b1;
`else
  localparam bit StatEn = 1'b0;
`endif

  int checks = 0;
  int errors = 0;

  // Model of the MEM-side architectural state.
  logic        m_valid, m_rw, m_mr, m_mw;
  logic [31:0] m_alu, m_sd, m_pc, m_red, m_ret;
  logic [4:0]  m_rd;
  logic [2:0]  m_dm;
  logic [1:0]  m_ws;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  task automatic idle();
    rst = 0; mem_stall = 0; ex_valid = 0; ex_flush = 0; ex_jalr = 0; ex_link = 0;
    ex_pc = 0; ex_imm = 0; ex_alu_c = 0; ex_rs2_data = 0; ex_rd = 0;
    ex_regwrite = 0; ex_memread = 0; ex_memwrite = 0; ex_dmtype = 0; ex_wdsel = 0;
  endtask

  task automatic model_reset();
    {m_valid, m_rw, m_mr, m_mw} = '0;
    m_alu = 0; m_sd = 0; m_pc = 0; m_red = 0; m_ret = 0; m_rd = 0; m_dm = 0; m_ws = 0;
  endtask

  task automatic check_regs();
    chk("mem_valid", 32'(mem_valid), 32'(m_valid));
    chk("mem_regwrite", 32'(mem_regwrite), 32'(m_rw));
    chk("mem_memread", 32'(mem_memread), 32'(m_mr));
    chk("mem_memwrite", 32'(mem_memwrite), 32'(m_mw));
    chk("mem_alu_out", mem_alu_out, m_alu);
    chk("mem_store_data", mem_store_data, m_sd);
    chk("mem_pc", mem_pc, m_pc);
    chk("mem_rd", 32'(mem_rd), 32'(m_rd));
    chk("mem_dmtype", 32'(mem_dmtype), 32'(m_dm));
    chk("mem_wdsel", 32'(mem_wdsel), 32'(m_ws));
    chk("stat_redirects", stat_redirects, StatEn ? m_red : 32'd0);
    chk("stat_retired", stat_retired, StatEn ? m_ret : 32'd0);
  endtask

  // Inputs are already applied; check combinational outputs, clock once, check registers.
  task automatic step();
    logic        rv;
    logic [31:0] tgt;
    #1;
    rv  = ex_valid && ex_flush && !mem_stall && !rst;
    tgt = ex_jalr ? {ex_alu_c[31:1], 1'b0} : ex_pc + ex_imm;
    chk("redirect_valid", 32'(redirect_valid), 32'(rv));
    chk("kill_ifid", 32'(kill_ifid), 32'(rv));
    chk("kill_idex", 32'(kill_idex), 32'(rv));
    chk("redirect_pc", redirect_pc, tgt);
    @(posedge clk);
    if (rst) model_reset();
    else if (!mem_stall) begin
      m_valid = ex_valid;
      m_rw = ex_valid && ex_regwrite;
      m_mr = ex_valid && ex_memread;
      m_mw = ex_valid && ex_memwrite;
      m_alu = ex_link ? ex_pc + 4 : ex_alu_c;
      m_sd = ex_rs2_data; m_pc = ex_pc; m_rd = ex_rd; m_dm = ex_dmtype; m_ws = ex_wdsel;
      if (rv && m_red != 32'hFFFF_FFFF) m_red++;
      if (ex_valid && m_ret != 32'hFFFF_FFFF) m_ret++;
    end
    #1;
    check_regs();
  endtask

  task automatic randomize_inputs();
    rst = ($urandom_range(0, 24) == 0);
    mem_stall = ($urandom_range(0, 3) == 0);
    ex_valid = ($urandom_range(0, 4) != 0);
    ex_flush = $urandom_range(0, 1) == 1;
    ex_jalr = $urandom_range(0, 1) == 1;
    ex_link = $urandom_range(0, 1) == 1;
    ex_pc = $urandom; ex_imm = $urandom; ex_alu_c = $urandom; ex_rs2_data = $urandom;
    ex_rd = 5'($urandom); ex_regwrite = 1'($urandom); ex_memread = 1'($urandom);
    ex_memwrite = 1'($urandom); ex_dmtype = 3'($urandom); ex_wdsel = 2'($urandom);
  endtask

  initial begin
    idle();
    model_reset();
    rst = 1;
    @(posedge clk); #1;
    step();
    chk("reset mem_valid", 32'(mem_valid), 32'd0);

    // Branch taken backwards.
    idle(); ex_valid = 1; ex_flush = 1; ex_pc = 32'h100; ex_imm = 32'hFFFF_FFF0;
    #1;
    chk("bt redirect_valid", 32'(redirect_valid), 32'd1);
    chk("bt redirect_pc", redirect_pc, 32'hF0);
    chk("bt kills", {30'd0, kill_ifid, kill_idex}, 32'd3);
    step();
    chk("bt mem_valid", 32'(mem_valid), 32'd1);
    chk("bt mem_pc", mem_pc, 32'h100);

    // JALR with link.
    idle(); ex_valid = 1; ex_flush = 1; ex_jalr = 1; ex_link = 1; ex_regwrite = 1;
    ex_alu_c = 32'h2003; ex_pc = 32'h40;
    #1;
    chk("jalr redirect_pc", redirect_pc, 32'h2002);
    step();
    chk("jalr mem_alu_out", mem_alu_out, 32'h44);
    chk("jalr mem_regwrite", 32'(mem_regwrite), 32'd1);

    // Known advance, then a redirecting branch held by a 3-cycle stall.
    idle(); ex_valid = 1; ex_pc = 32'h200;
    step();
    idle(); ex_valid = 1; ex_flush = 1; ex_pc = 32'h300; ex_imm = 32'h20; mem_stall = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall mem_pc", mem_pc, 32'h200);
      chk("stall no redirect", 32'(redirect_valid), 32'd0);
    end
    mem_stall = 0;
    #1;
    chk("release redirect", 32'(redirect_valid), 32'd1);
    step();
    chk("release mem_pc", mem_pc, 32'h300);

    // Bubble with flush and memwrite set.
    idle(); ex_flush = 1; ex_memwrite = 1;
    step();
    chk("bubble mem_memwrite", 32'(mem_memwrite), 32'd0);

    // Reset together with a live redirect.
    idle(); ex_valid = 1; ex_flush = 1; ex_pc = 32'h500; rst = 1;
    #1;
    chk("rst redirect_valid", 32'(redirect_valid), 32'd0);
    step();
    chk("rst mem_pc", mem_pc, 32'd0);
    chk("rst stat_retired", stat_retired, 32'd0);

`ifdef BRANCH_STAT_EN
    force dut.stat_ret_q = 32'hFFFF_FFFF;
    #0 release dut.stat_ret_q;
    m_ret = 32'hFFFF_FFFF;
    idle(); ex_valid = 1;
    step();
    chk("sat stat_retired", stat_retired, 32'hFFFF_FFFF);
`endif

    for (int n = 0; n < 400; n++) begin
      randomize_inputs();
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
